// File: rtl/mac_rx_frontend.sv
// MAC receive front end: MII/GMII input, preamble/SFD strip, byte + descriptor writes
// to external FIFOs, whole-frame drop on backpressure, saturating frame/drop counters.
`timescale 1ns/1ps

module crc32_8023 (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  d,
  input  logic        load_init,
  input  logic        calc,
  input  logic        d_valid,
  output logic [31:0] crc_reg
);
  // MSB-feedback LFSR fed LSB first; a good frame leaves the 802.3 residue in crc_reg.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 crc_reg <= 32'hFFFFFFFF;
    else if (load_init)        crc_reg <= 32'hFFFFFFFF;
    else if (calc && d_valid)  crc_reg <= crc_step(crc_reg, d);
  end
endmodule

module mac_rx_frontend #(
  parameter int          NIBBLE_MODE = 1,
  parameter int          MIN_LEN     = 64,
  parameter int          MAX_LEN     = 1518,
  parameter logic [31:0] CRC_RESIDUE = 32'hc704dd7b,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_dv,
  input  logic             rx_er,
  input  logic [7:0]       rx_d,
  input  logic [11:0]      data_fifo_space,
  input  logic             ptr_fifo_full,
  output logic             data_wr,
  output logic [7:0]       data_out,
  output logic             ptr_wr,
  output logic [15:0]      ptr_dout,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy,
  output logic [2:0]       dbg_state
);
  // Handshake: data_wr and ptr_wr are write strobes with no ready; the FIFOs must accept
  // every strobe. Flow control is by space check at frame start only.
  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, EOF1, EOF2, DESC, DISCARD} state_t;

  localparam logic        MII   = (NIBBLE_MODE != 0);
  localparam logic [11:0] MAX_L = 12'(MAX_LEN);
  localparam logic [11:0] MIN_L = 12'(MIN_LEN);

  state_t      state, state_n;
  logic [7:0]  rx_d_q;
  logic        rx_dv_q, rx_er_q, q_valid, armed;
  logic        phase;
  logic [3:0]  low_nib;
  logic [7:0]  byte_r;
  logic        byte_v;
  logic [11:0] byte_cnt;
  logic        truncated, align_err, rx_er_seen;
  logic [31:0] crc_reg;

  logic        sfd_beat, bp, byte_done, enter_data, drop_inc, desc_wr;
  logic [7:0]  byte_asm;

  assign sfd_beat  = MII ? (rx_d_q[3:0] == 4'hD) : (rx_d_q == 8'hD5);
  assign bp        = (data_fifo_space < MAX_L) | ptr_fifo_full;
  assign byte_done = (state == DATA) & rx_dv_q & (MII ? phase : 1'b1);
  assign byte_asm  = MII ? {rx_d_q[3:0], low_nib} : rx_d_q;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // q_valid keeps the reset value of rx_dv_q from arming the receiver.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_d_q  <= 8'h00;
      rx_dv_q <= 1'b0;
      rx_er_q <= 1'b0;
      q_valid <= 1'b0;
      armed   <= 1'b0;
    end else begin
      rx_d_q  <= rx_d;
      rx_dv_q <= rx_dv;
      rx_er_q <= rx_er;
      q_valid <= 1'b1;
      if (q_valid && !rx_dv_q) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    enter_data = 1'b0;
    drop_inc   = 1'b0;
    desc_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (armed && rx_dv_q) begin
          if (bp) begin
            state_n  = DISCARD;
            drop_inc = 1'b1;
          end else if (sfd_beat) begin
            state_n    = DATA;
            enter_data = 1'b1;
          end else begin
            state_n = PREAMBLE;
          end
        end
      end
      PREAMBLE: begin
        if (!rx_dv_q) state_n = IDLE;
        else if (sfd_beat) begin
          state_n    = DATA;
          enter_data = 1'b1;
        end
      end
      DATA:    if (!rx_dv_q) state_n = EOF1;
      EOF1:    state_n = EOF2;
      EOF2: begin
        state_n = DESC;
        desc_wr = 1'b1;
      end
      DESC:    state_n = IDLE;
      DISCARD: if (!rx_dv_q) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= 1'b0;
      low_nib    <= 4'h0;
      byte_r     <= 8'h00;
      byte_v     <= 1'b0;
      byte_cnt   <= 12'd0;
      truncated  <= 1'b0;
      align_err  <= 1'b0;
      rx_er_seen <= 1'b0;
    end else begin
      byte_v <= byte_done & (byte_cnt < MAX_L);
      if (enter_data) begin
        phase      <= 1'b0;
        byte_cnt   <= 12'd0;
        truncated  <= 1'b0;
        align_err  <= 1'b0;
        rx_er_seen <= 1'b0;
        byte_v     <= 1'b0;
      end else if (state == DATA) begin
        if (rx_dv_q) begin
          if (rx_er_q) rx_er_seen <= 1'b1;
          if (MII && !phase) begin
            low_nib <= rx_d_q[3:0];
            phase   <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (byte_cnt < MAX_L) begin
              byte_r   <= byte_asm;
              byte_cnt <= byte_cnt + 12'd1;
            end else begin
              truncated <= 1'b1;
            end
          end
        end else begin
          align_err <= MII & phase;
        end
      end
    end
  end

  crc32_8023 u_crc (
    .clk       (clk),
    .reset     (reset),
    .d         (byte_r),
    .load_init (enter_data),
    .calc      (byte_v),
    .d_valid   (byte_v),
    .crc_reg   (crc_reg)
  );

  // Second pipeline stage: the FIFO write lands alongside the CRC update of the same byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_wr   <= 1'b0;
      data_out  <= 8'h00;
      ptr_wr    <= 1'b0;
      ptr_dout  <= 16'h0000;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      data_wr <= byte_v;
      if (byte_v) data_out <= byte_r;
      ptr_wr <= desc_wr;
      if (desc_wr) begin
        ptr_dout <= {(crc_reg != CRC_RESIDUE), (byte_cnt < MIN_L) | truncated,
                     align_err, rx_er_seen, byte_cnt};
        if (frame_cnt != {CNT_W{1'b1}}) frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (drop_inc && drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mac_rx_frontend.sv
// Bench for mac_rx_frontend: one MII and one GMII instance, frames built with a
// reference reflected CRC-32, byte and descriptor scoreboards checked on the falling edge.
`timescale 1ns/1ps

module tb_mac_rx_frontend;
  localparam int MAX_LEN = 1518;
  localparam int MIN_LEN = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        m_rx_dv = 1'b0, m_rx_er = 1'b0, m_pfull = 1'b0;
  logic [7:0]  m_rx_d = 8'h00;
  logic [11:0] m_space = 12'd4095;
  logic        m_data_wr, m_ptr_wr, m_busy;
  logic [7:0]  m_data_out;
  logic [15:0] m_ptr_dout, m_frame_cnt, m_drop_cnt;
  logic [2:0]  m_dbg;

  logic        g_rx_dv = 1'b0, g_rx_er = 1'b0, g_pfull = 1'b0;
  logic [7:0]  g_rx_d = 8'h00;
  logic [11:0] g_space = 12'd4095;
  logic        g_data_wr, g_ptr_wr, g_busy;
  logic [7:0]  g_data_out;
  logic [15:0] g_ptr_dout, g_frame_cnt, g_drop_cnt;
  logic [2:0]  g_dbg;

  mac_rx_frontend #(.NIBBLE_MODE(1)) u_mii (
    .clk(clk), .reset(reset), .rx_dv(m_rx_dv), .rx_er(m_rx_er), .rx_d(m_rx_d),
    .data_fifo_space(m_space), .ptr_fifo_full(m_pfull), .data_wr(m_data_wr),
    .data_out(m_data_out), .ptr_wr(m_ptr_wr), .ptr_dout(m_ptr_dout),
    .frame_cnt(m_frame_cnt), .drop_cnt(m_drop_cnt), .busy(m_busy), .dbg_state(m_dbg)
  );

  mac_rx_frontend #(.NIBBLE_MODE(0)) u_gmii (
    .clk(clk), .reset(reset), .rx_dv(g_rx_dv), .rx_er(g_rx_er), .rx_d(g_rx_d),
    .data_fifo_space(g_space), .ptr_fifo_full(g_pfull), .data_wr(g_data_wr),
    .data_out(g_data_out), .ptr_wr(g_ptr_wr), .ptr_dout(g_ptr_dout),
    .frame_cnt(g_frame_cnt), .drop_cnt(g_drop_cnt), .busy(g_busy), .dbg_state(g_dbg)
  );

  logic [7:0]  m_exp_q[$], g_exp_q[$];
  logic [15:0] m_ptr_q[$], g_ptr_q[$];
  logic [7:0]  m_e, g_e;
  logic [15:0] m_pe, g_pe;
  bit mon_en = 1'b1;
  int checks = 0, failures = 0;
  int m_first_wr = -1, g_first_wr = -1;
  int beat_cyc = 0, ptr_lat = 0;
  logic [7:0] frm [0:1599];

  // Scoreboards: every strobe pops one expected entry.
  always @(negedge clk) begin
    if (mon_en && m_data_wr === 1'b1) begin
      if (m_first_wr < 0) m_first_wr = cyc;
      checks++;
      if (m_exp_q.size() == 0) begin
        failures++; $display("FAIL m_data unexpected write got=%h", m_data_out);
      end else begin
        m_e = m_exp_q.pop_front();
        if (m_data_out !== m_e) begin failures++; $display("FAIL m_data got=%h exp=%h", m_data_out, m_e); end
      end
    end
    if (mon_en && m_ptr_wr === 1'b1) begin
      checks++;
      if (m_ptr_q.size() == 0) begin
        failures++; $display("FAIL m_ptr unexpected write got=%h", m_ptr_dout);
      end else begin
        m_pe = m_ptr_q.pop_front();
        if (m_ptr_dout !== m_pe) begin failures++; $display("FAIL m_ptr got=%h exp=%h", m_ptr_dout, m_pe); end
      end
    end
    if (mon_en && g_data_wr === 1'b1) begin
      if (g_first_wr < 0) g_first_wr = cyc;
      checks++;
      if (g_exp_q.size() == 0) begin
        failures++; $display("FAIL g_data unexpected write got=%h", g_data_out);
      end else begin
        g_e = g_exp_q.pop_front();
        if (g_data_out !== g_e) begin failures++; $display("FAIL g_data got=%h exp=%h", g_data_out, g_e); end
      end
    end
    if (mon_en && g_ptr_wr === 1'b1) begin
      checks++;
      if (g_ptr_q.size() == 0) begin
        failures++; $display("FAIL g_ptr unexpected write got=%h", g_ptr_dout);
      end else begin
        g_pe = g_ptr_q.pop_front();
        if (g_ptr_dout !== g_pe) begin failures++; $display("FAIL g_ptr got=%h exp=%h", g_ptr_dout, g_pe); end
      end
    end
  end

  task automatic drive_beat(input bit gmii, input logic [7:0] v, input logic dv, input logic er);
    @(posedge clk); #1;
    if (gmii) begin
      g_rx_dv = dv; g_rx_d = v; g_rx_er = er;
    end else begin
      m_rx_dv = dv; m_rx_d = {4'($urandom_range(0, 15)), v[3:0]}; m_rx_er = er;
    end
  endtask

  // Builds n bytes (payload + FCS), pushes expectations when accepted, drives it, idles 12 cycles.
  task automatic send_frame(input bit gmii, input int n, input bit flip, input bit trail,
                            input int er_at, input bit accept);
    logic [31:0] c;
    logic [15:0] desc;
    logic [7:0]  b;
    int nw;
    for (int i = 0; i < n - 4; i++) frm[i] = 8'($urandom_range(0, 255));
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n - 4; i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    frm[n-4] = c[7:0]; frm[n-3] = c[15:8]; frm[n-2] = c[23:16]; frm[n-1] = c[31:24];
    if (flip) frm[10] = frm[10] ^ 8'h01;
    nw = (n > MAX_LEN) ? MAX_LEN : n;
    if (accept) begin
      for (int i = 0; i < nw; i++) begin
        if (gmii) g_exp_q.push_back(frm[i]); else m_exp_q.push_back(frm[i]);
      end
      desc = {flip | (n > MAX_LEN), (n < MIN_LEN) | (n > MAX_LEN), trail & !gmii,
              er_at >= 0, 12'(nw)};
      if (gmii) g_ptr_q.push_back(desc); else m_ptr_q.push_back(desc);
    end
    m_first_wr = -1; g_first_wr = -1; ptr_lat = 0;
    if (gmii) begin
      for (int i = 0; i < 7; i++) drive_beat(1'b1, 8'h55, 1'b1, 1'b0);
      drive_beat(1'b1, 8'hD5, 1'b1, 1'b0);
    end else begin
      for (int i = 0; i < 15; i++) drive_beat(1'b0, 8'h05, 1'b1, 1'b0);
      drive_beat(1'b0, 8'h0D, 1'b1, 1'b0);
    end
    for (int i = 0; i < n; i++) begin
      b = frm[i];
      if (gmii) begin
        drive_beat(1'b1, b, 1'b1, i == er_at);
      end else begin
        drive_beat(1'b0, b, 1'b1, i == er_at);
        drive_beat(1'b0, {4'h0, b[7:4]}, 1'b1, i == er_at);
      end
      if (i == 0) beat_cyc = cyc + 1;
    end
    if (trail) drive_beat(1'b0, 8'h07, 1'b1, 1'b0);
    drive_beat(gmii, 8'h00, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (ptr_lat == 0 && (gmii ? g_ptr_wr : m_ptr_wr) === 1'b1) ptr_lat = k;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_data_wr, m_data_out, m_ptr_wr, m_ptr_dout, m_frame_cnt, m_drop_cnt, m_busy} !== '0) begin
      failures++; $display("FAIL reset_mii outputs not zero wr=%b ptr=%h fc=%0d", m_data_wr, m_ptr_dout, m_frame_cnt);
    end
    checks++;
    if ({g_data_wr, g_data_out, g_ptr_wr, g_ptr_dout, g_frame_cnt, g_drop_cnt, g_busy} !== '0) begin
      failures++; $display("FAIL reset_gmii outputs not zero wr=%b ptr=%h fc=%0d", g_data_wr, g_ptr_dout, g_frame_cnt);
    end
    @(negedge clk); reset = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_good_frame;
    send_frame(1'b0, 64, 1'b0, 1'b0, -1, 1'b1);
    checks++;
    if (m_exp_q.size() != 0 || m_ptr_q.size() != 0) begin
      failures++; $display("FAIL good_frame pending data=%0d ptr=%0d exp=0", m_exp_q.size(), m_ptr_q.size());
    end
    checks++;
    if (m_frame_cnt !== 16'd1) begin failures++; $display("FAIL good_frame_cnt got=%0d exp=1", m_frame_cnt); end
    checks++;
    if (ptr_lat != 4) begin failures++; $display("FAIL good_ptr_latency got=%0d exp=4", ptr_lat); end
    checks++;
    if (m_first_wr - beat_cyc != 2) begin
      failures++; $display("FAIL good_data_latency got=%0d exp=2", m_first_wr - beat_cyc);
    end
    checks++;
    if (m_busy !== 1'b0) begin failures++; $display("FAIL good_busy got=%b exp=0", m_busy); end
  endtask

  task automatic test_crc_error;
    send_frame(1'b0, 64, 1'b1, 1'b0, -1, 1'b1);
    checks++;
    if (m_exp_q.size() != 0 || m_ptr_q.size() != 0 || m_frame_cnt !== 16'd2) begin
      failures++; $display("FAIL crc_error pending=%0d fc=%0d exp fc=2", m_exp_q.size(), m_frame_cnt);
    end
  endtask

  task automatic test_length;
    send_frame(1'b0, 40, 1'b0, 1'b0, -1, 1'b1);
    send_frame(1'b0, 1600, 1'b0, 1'b0, -1, 1'b1);
    checks++;
    if (m_exp_q.size() != 0 || m_ptr_q.size() != 0 || m_frame_cnt !== 16'd4) begin
      failures++; $display("FAIL length pending=%0d ptr=%0d fc=%0d exp fc=4", m_exp_q.size(), m_ptr_q.size(), m_frame_cnt);
    end
  endtask

  task automatic test_backpressure;
    m_space = 12'd1000;
    send_frame(1'b0, 64, 1'b0, 1'b0, -1, 1'b0);
    m_space = 12'd4095;
    checks++;
    if (m_drop_cnt !== 16'd1) begin failures++; $display("FAIL bp_drop_cnt got=%0d exp=1", m_drop_cnt); end
    checks++;
    if (m_frame_cnt !== 16'd4 || ptr_lat != 0) begin
      failures++; $display("FAIL bp_no_desc fc=%0d lat=%0d exp fc=4 lat=0", m_frame_cnt, ptr_lat);
    end
    // Space falling after the frame has started must not affect it.
    fork
      send_frame(1'b0, 64, 1'b0, 1'b0, -1, 1'b1);
      begin repeat (60) @(posedge clk); #1 m_space = 12'd10; end
    join
    m_space = 12'd4095;
    checks++;
    if (m_exp_q.size() != 0 || m_ptr_q.size() != 0 || m_frame_cnt !== 16'd5 || m_drop_cnt !== 16'd1) begin
      failures++; $display("FAIL bp_recover pending=%0d fc=%0d dc=%0d exp fc=5 dc=1", m_exp_q.size(), m_frame_cnt, m_drop_cnt);
    end
  endtask

  task automatic test_align;
    send_frame(1'b0, 64, 1'b0, 1'b1, -1, 1'b1);
    checks++;
    if (m_exp_q.size() != 0 || m_ptr_q.size() != 0 || m_frame_cnt !== 16'd6) begin
      failures++; $display("FAIL align pending=%0d fc=%0d exp fc=6", m_exp_q.size(), m_frame_cnt);
    end
  endtask

  task automatic test_gmii_rx_er;
    send_frame(1'b1, 64, 1'b0, 1'b0, 20, 1'b1);
    checks++;
    if (g_exp_q.size() != 0 || g_ptr_q.size() != 0 || g_frame_cnt !== 16'd1) begin
      failures++; $display("FAIL gmii_rx_er pending=%0d fc=%0d exp fc=1", g_exp_q.size(), g_frame_cnt);
    end
    checks++;
    if (ptr_lat != 4) begin failures++; $display("FAIL gmii_ptr_latency got=%0d exp=4", ptr_lat); end
    checks++;
    if (g_first_wr - beat_cyc != 2) begin
      failures++; $display("FAIL gmii_data_latency got=%0d exp=2", g_first_wr - beat_cyc);
    end
  endtask

  task automatic test_back_to_back;
    send_frame(1'b1, 64, 1'b0, 1'b0, -1, 1'b1);
    send_frame(1'b1, 70, 1'b0, 1'b0, -1, 1'b1);
    checks++;
    if (g_exp_q.size() != 0 || g_ptr_q.size() != 0 || g_frame_cnt !== 16'd3) begin
      failures++; $display("FAIL back_to_back pending=%0d fc=%0d exp fc=3", g_exp_q.size(), g_frame_cnt);
    end
  endtask

  task automatic test_reset_mid_frame;
    mon_en = 1'b0;
    fork
      send_frame(1'b0, 64, 1'b0, 1'b0, -1, 1'b0);
      begin
        repeat (60) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({m_data_wr, m_data_out, m_ptr_wr, m_ptr_dout, m_frame_cnt, m_drop_cnt, m_busy} !== '0) begin
          failures++; $display("FAIL mid_reset outputs not zero wr=%b fc=%0d busy=%b", m_data_wr, m_frame_cnt, m_busy);
        end
        @(posedge clk); #2 reset = 1'b0;
        m_exp_q.delete(); m_ptr_q.delete();
        mon_en = 1'b1;
      end
    join
    checks++;
    if (m_frame_cnt !== 16'd0 || m_busy !== 1'b0) begin
      failures++; $display("FAIL mid_reset_ignored fc=%0d busy=%b exp fc=0 busy=0", m_frame_cnt, m_busy);
    end
    send_frame(1'b0, 64, 1'b0, 1'b0, -1, 1'b1);
    checks++;
    if (m_exp_q.size() != 0 || m_ptr_q.size() != 0 || m_frame_cnt !== 16'd1) begin
      failures++; $display("FAIL mid_reset_next pending=%0d fc=%0d exp fc=1", m_exp_q.size(), m_frame_cnt);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_good_frame;
    test_crc_error;
    test_length;
    test_backpressure;
    test_align;
    test_gmii_rx_er;
    test_back_to_back;
    test_reset_mid_frame;
    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
